// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and state encoding for the EX-stage multiply/divide unit
package cpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface ex_muldiv_if;
  import cpu_pkg::*;

  logic              req_valid;
  logic [1:0]        req_op;
  logic              req_ready;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              flush;
  logic              busy;
  logic              res_valid;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              div_zero;

  modport master (
    output req_valid, req_op, src1, src2, flush,
    input  req_ready, busy, res_valid, res_hi, res_lo, div_zero
  );

  modport slave (
    input  req_valid, req_op, src1, src2, flush,
    output req_ready, busy, res_valid, res_hi, res_lo, div_zero
  );

endinterface

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring-division step on the {rem, quo} pair
module div_iter_step
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;
  logic              keep;

  always_comb begin
    rem_sh = {rem_i, quo_i[DATA_W-1]};
    keep   = (rem_sh >= {1'b0, dvs_i});
    // when the subtraction is kept the true result is below the divisor, so 32 bits suffice
    diff   = rem_sh[DATA_W-1:0] - dvs_i;
    rem_o  = keep ? diff : rem_sh[DATA_W-1:0];
    quo_o  = {quo_i[DATA_W-2:0], keep};
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle MULT/MULTU/DIV/DIVU unit; MULDIV_DIVZERO_EN enables the divide-by-zero shortcut and flag
module ex_muldiv
  import cpu_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  ex_muldiv_if.slave  io
);

  md_state_e         state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              init_q, init_d;
`ifdef MULDIV_DIVZERO_EN
  logic              dz_q, dz_d;
`endif

  logic                ready;
  logic                accept;
  logic                last_iter;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   step_rem, step_quo;

  assign ready     = (state_q == MD_IDLE) || (state_q == MD_DONE);
  assign accept    = io.req_valid & ready & ~io.flush;
  assign last_iter = (cnt_q == 6'(DIV_ITER - 1));

  // op bit 0 clear means signed (MULT, DIV)
  assign a_neg = ~op_q[0] & a_q[DATA_W-1];
  assign b_neg = ~op_q[0] & b_q[DATA_W-1];
  assign abs_a = a_neg ? (DATA_W'(0) - a_q) : a_q;
  assign abs_b = b_neg ? (DATA_W'(0) - b_q) : b_q;
  // low 64 bits of the extended product are correct for both signed and unsigned
  assign prod  = {{DATA_W{a_neg}}, a_q} * {{DATA_W{b_neg}}, b_q};

  div_iter_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= MD_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (accept) state_d = io.req_op[1] ? MD_DIV : MD_MUL;
        else        state_d = MD_IDLE;
      end
      MD_MUL: state_d = io.flush ? MD_IDLE : MD_DONE;
      MD_DIV: begin
        if (io.flush) state_d = MD_IDLE;
`ifdef MULDIV_DIVZERO_EN
        else if (init_q && dz_q) state_d = MD_DONE;
`endif
        else if (!init_q && last_iter) state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    io.req_ready = ready;
    io.busy      = ~ready;
    io.res_valid = (state_q == MD_DONE) & ~io.flush;
    io.res_hi    = res_hi_q;
    io.res_lo    = res_lo_q;
`ifdef MULDIV_DIVZERO_EN
    io.div_zero  = (state_q == MD_DONE) & ~io.flush & dz_q;
`else
    io.div_zero  = 1'b0;
`endif
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    cnt_d    = cnt_q;
    init_d   = init_q;
`ifdef MULDIV_DIVZERO_EN
    dz_d     = dz_q;
`endif
    if (accept) begin
      op_d   = io.req_op;
      a_d    = io.src1;
      b_d    = io.src2;
      cnt_d  = '0;
      init_d = 1'b1;
`ifdef MULDIV_DIVZERO_EN
      dz_d   = io.req_op[1] && (io.src2 == '0);
`endif
    end else if (state_q == MD_MUL && !io.flush) begin
      {res_hi_d, res_lo_d} = prod;
    end else if (state_q == MD_DIV && !io.flush) begin
      if (init_q) begin
        // first DIV cycle turns the operands into magnitudes before iterating
        init_d = 1'b0;
        rem_d  = '0;
        quo_d  = abs_a;
        dvs_d  = abs_b;
`ifdef MULDIV_DIVZERO_EN
        if (dz_q) begin
          res_hi_d = a_q;
          res_lo_d = '1;
        end
`endif
      end else begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (last_iter) begin
          res_lo_d = (a_neg ^ b_neg) ? (DATA_W'(0) - step_quo) : step_quo;
          res_hi_d = a_neg ? (DATA_W'(0) - step_rem) : step_rem;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      cnt_q    <= '0;
      init_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
`ifdef MULDIV_DIVZERO_EN
      dz_q     <= dz_d;
`endif
    end
  end

endmodule
